// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg
//   Shared constants and types for the PWM control blocks.
//   DC_W / DC_MAX match the PWM generator duty-cycle inputs; CLK_HZ is the
//   PWM clock and RAMP_TICK_HZ the default soft-start step rate.
package pwm_ctrl_pkg;

    localparam int DC_W         = 7;
    localparam int DC_MAX       = 100;
    localparam int CLK_HZ       = 12_000_000;
    localparam int RAMP_TICK_HZ = 1_000;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_e;

endpackage

// File: rtl/pwm_tick_div.sv
// pwm_tick_div
//   Down-counting tick divider: emits a 1-cycle tick once every TICK_DIV
//   enabled cycles. The count holds while en=0 and restarts on clr.
//   Ports:
//     clk    system clock
//     rst_n  synchronous active-low reset
//     en     count enable
//     clr    synchronous restart of the period
//     tick   1-cycle pulse on the last cycle of each period
module pwm_tick_div #(
    parameter int TICK_DIV = 12000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             CNT_W  = 16;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // The tick is taken in the same cycle the count reaches zero, so the
    // consumer sees it exactly TICK_DIV enabled cycles after a restart.
    assign tick = en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= RELOAD;
        end else if (tick) begin
            cnt <= RELOAD;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pwm_dc_ramp_ctrl.sv
// pwm_dc_ramp_ctrl
//   Soft-start duty-cycle sequencer. Accepts a target duty over valid/ready
//   and slews reg_dc toward it by STEP once per TICK_DIV clocks.
//   Ports:
//     clk        system clock (12 MHz)
//     rst_n      synchronous active-low reset
//     enable     1 = ramp runs, 0 = ramp frozen
//     abort      1-cycle request: duty to 0, drop current ramp
//     tgt_dc     requested target duty
//     tgt_valid  target request valid
//     tgt_ready  controller can accept a target (combinational)
//     reg_dc     registered duty value to the PWM generator
//     busy       ramp in progress
//     done       1-cycle pulse when reg_dc reaches the target
module pwm_dc_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int TICK_DIV = CLK_HZ / RAMP_TICK_HZ,
    parameter int STEP     = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            abort,
    input  logic [DC_W-1:0] tgt_dc,
    input  logic            tgt_valid,
    output logic            tgt_ready,
    output logic [DC_W-1:0] reg_dc,
    output logic            busy,
    output logic            done
);

    localparam logic [DC_W:0]   STEP_X   = (DC_W + 1)'(STEP);
    localparam logic [DC_W-1:0] DC_MAX_V = DC_W'(DC_MAX);

    ramp_state_e     state, state_nxt;
    logic [DC_W-1:0] target, target_nxt;
    logic [DC_W-1:0] reg_dc_nxt;
    logic            done_nxt;
    logic [DC_W-1:0] tgt_clamped;
    logic [DC_W-1:0] stepped;
    logic [DC_W:0]   dc_x, tgt_x;
    logic            handshake;
    logic            tick, tick_en, tick_clr;

    assign tgt_ready   = rst_n && !abort && (state == IDLE);
    assign handshake   = tgt_valid && tgt_ready;
    assign busy        = (state == RAMP);
    assign tgt_clamped = (tgt_dc > DC_MAX_V) ? DC_MAX_V : tgt_dc;
    assign tick_en     = enable && (state == RAMP);

    pwm_tick_div #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Step arithmetic is one bit wider than the duty so neither the sum nor
    // target+STEP can wrap; the result saturates at the target.
    assign dc_x  = {1'b0, reg_dc};
    assign tgt_x = {1'b0, target};

    always_comb begin
        stepped = reg_dc;
        if (dc_x < tgt_x) begin
            if (dc_x + STEP_X >= tgt_x) begin
                stepped = target;
            end else begin
                stepped = reg_dc + STEP_X[DC_W-1:0];
            end
        end else if (dc_x > tgt_x) begin
            if (dc_x <= tgt_x + STEP_X) begin
                stepped = target;
            end else begin
                stepped = reg_dc - STEP_X[DC_W-1:0];
            end
        end
    end

    // abort outranks both the tick and a handshake in the same cycle.
    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        reg_dc_nxt = reg_dc;
        done_nxt   = 1'b0;
        tick_clr   = 1'b0;
        if (abort) begin
            state_nxt  = IDLE;
            target_nxt = '0;
            reg_dc_nxt = '0;
            tick_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        target_nxt = tgt_clamped;
                        tick_clr   = 1'b1;
                        if (tgt_clamped == reg_dc) begin
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt = RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (tick) begin
                        reg_dc_nxt = stepped;
                        if (stepped == target) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            target <= '0;
            reg_dc <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            target <= target_nxt;
            reg_dc <= reg_dc_nxt;
            done   <= done_nxt;
        end
    end

endmodule
